// File: rtl/rv_opcodes_pkg.sv
// Shared RISC-V major-opcode constants and the format-classification record
// used by ir_decode, immpicker users and the execute stage.
package rv_opcodes;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;

  // One-hot format flags (at most one set) plus the illegal marker.
  typedef struct packed {
    logic type_i;
    logic type_s;
    logic type_sb;
    logic type_u;
    logic type_uj;
    logic illegal;
  } iclass_t;

  localparam iclass_t ICLASS_NONE = '0;

endpackage

// File: rtl/ir_decode_opclass.sv
// Combinational opcode classifier: maps a 32-bit instruction word onto the
// immpicker format flags and an illegal-opcode marker.
module opclass
  import rv_opcodes::*;
(
  input  logic [31:0] inst_i,
  output logic        type_i_o,
  output logic        type_s_o,
  output logic        type_sb_o,
  output logic        type_u_o,
  output logic        type_uj_o,
  output logic        illegal_o
);

  // Only the major opcode matters; the rest of the word is deliberately ignored.
  logic unused_upper;
  assign unused_upper = ^inst_i[31:7];

  always_comb begin
    type_i_o  = 1'b0;
    type_s_o  = 1'b0;
    type_sb_o = 1'b0;
    type_u_o  = 1'b0;
    type_uj_o = 1'b0;
    illegal_o = 1'b0;
    if (inst_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (inst_i[6:0])
        OP_LOAD, OP_MISC_MEM, OP_OP_IMM,
        OP_OP_IMM_32, OP_JALR, OP_SYSTEM: type_i_o  = 1'b1;
        OP_STORE:                         type_s_o  = 1'b1;
        OP_BRANCH:                        type_sb_o = 1'b1;
        OP_LUI, OP_AUIPC:                 type_u_o  = 1'b1;
        OP_JAL:                           type_uj_o = 1'b1;
        OP_OP, OP_OP_32:                  ;
        default:                          illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ir_decode.sv
// Instruction register + format classification between fetch and immpicker.
// Define IR_DECODE_SKID_EN to add a one-entry skid buffer (registered f_ready_o).
module ir_decode
  import rv_opcodes::*;
#(
  parameter int PC_W = 64
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            flush_i,
  input  logic            f_valid_i,
  output logic            f_ready_o,
  input  logic [31:0]     f_inst_i,
  input  logic [PC_W-1:0] f_pc_i,
  output logic            d_valid_o,
  input  logic            d_ready_i,
  output logic [31:0]     d_inst_o,
  output logic [PC_W-1:0] d_pc_o,
  output logic            d_typeI_o,
  output logic            d_typeS_o,
  output logic            d_typeSB_o,
  output logic            d_typeU_o,
  output logic            d_typeUJ_o,
  output logic            d_illegal_o
);

  logic            valid_q, valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] pc_q, pc_d;
  iclass_t         cls_q, cls_d;

  logic            accept;
  logic [31:0]     src_inst;
  iclass_t         src_cls;

  opclass u_opclass (
    .inst_i    (src_inst),
    .type_i_o  (src_cls.type_i),
    .type_s_o  (src_cls.type_s),
    .type_sb_o (src_cls.type_sb),
    .type_u_o  (src_cls.type_u),
    .type_uj_o (src_cls.type_uj),
    .illegal_o (src_cls.illegal)
  );

`ifdef IR_DECODE_SKID_EN

  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_inst_q, skid_inst_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic            main_free;

  assign f_ready_o = ~skid_valid_q;
  assign accept    = f_valid_i & f_ready_o;
  assign main_free = ~valid_q | d_ready_i;
  // The classifier looks at whichever word is about to enter the main register.
  assign src_inst  = skid_valid_q ? skid_inst_q : f_inst_i;

  always_comb begin
    valid_d      = valid_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    cls_d        = cls_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      cls_d        = ICLASS_NONE;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Fetch is blocked while skid is full, so only skid->main can move.
      if (main_free) begin
        valid_d      = 1'b1;
        inst_d       = skid_inst_q;
        pc_d         = skid_pc_q;
        cls_d        = src_cls;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_free) begin
        valid_d = 1'b1;
        inst_d  = f_inst_i;
        pc_d    = f_pc_i;
        cls_d   = src_cls;
      end else begin
        skid_valid_d = 1'b1;
        skid_inst_d  = f_inst_i;
        skid_pc_d    = f_pc_i;
      end
    end else if (d_ready_i) begin
      valid_d = 1'b0;
      cls_d   = ICLASS_NONE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`else

  assign f_ready_o = ~valid_q | d_ready_i;
  assign accept    = f_valid_i & f_ready_o;
  assign src_inst  = f_inst_i;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    cls_d   = cls_q;
    if (flush_i) begin
      valid_d = 1'b0;
      cls_d   = ICLASS_NONE;
    end else if (accept) begin
      valid_d = 1'b1;
      inst_d  = f_inst_i;
      pc_d    = f_pc_i;
      cls_d   = src_cls;
    end else if (d_ready_i) begin
      valid_d = 1'b0;
      cls_d   = ICLASS_NONE;
    end
  end

`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      cls_q   <= ICLASS_NONE;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      cls_q   <= cls_d;
    end
  end

  assign d_valid_o   = valid_q;
  assign d_inst_o    = inst_q;
  assign d_pc_o      = pc_q;
  assign d_typeI_o   = cls_q.type_i;
  assign d_typeS_o   = cls_q.type_s;
  assign d_typeSB_o  = cls_q.type_sb;
  assign d_typeU_o   = cls_q.type_u;
  assign d_typeUJ_o  = cls_q.type_uj;
  assign d_illegal_o = cls_q.illegal;

endmodule
